// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth table scanner.
//   state_t    : scan FSM states
//   N_VECTORS  : number of input vectors of a 3-input function
//   IDX_W      : width of the vector index
package truth_table_scanner_pkg;

    localparam int N_VECTORS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_scanner_settle.sv
// settle_timer: down-counter that measures how long a vector has been applied.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over count)
//   load_val   : cycles-minus-one to wait
//   count      : decrement while nonzero
//   expire     : counter has reached zero
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (count && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Derived from the counter register only, so no input-to-output path.
    assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: applies all 8 vectors to a 3-input function, holds each
// for SETTLE cycles, samples f one cycle later and compares the captured table
// against a golden table latched at start.
//   clk, reset    : clock, synchronous active-high reset
//   start         : begin a scan (ignored while busy)
//   expected[7:0] : golden table, bit i = f for vector i
//   a, b, c       : registered stimulus, {a,b,c} = vector index
//   f             : response of the function under test
//   busy, done    : scan in progress / one-cycle end-of-scan pulse
//   pass          : captured table equals latched golden table
//   f_table[7:0]  : captured f values
//   mismatch[7:0] : f_table ^ latched golden table
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_VECTORS-1:0] expected,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_VECTORS-1:0] f_table,
    output logic [N_VECTORS-1:0] mismatch
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_VECTORS - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     vec;
    logic [N_VECTORS-1:0] exp_q;
    logic [N_VECTORS-1:0] tbl_nxt;
    logic                 tmr_load;
    logic                 tmr_count;
    logic                 tmr_expire;

    // Table including the bit being sampled this cycle; lets pass/mismatch be
    // registered on the same edge that enters DONE.
    always_comb begin
        tbl_nxt      = f_table;
        tbl_nxt[idx] = f;
    end

    assign tmr_load  = (state == IDLE && start) || (state == SAMPLE && idx != LAST_IDX);
    assign tmr_count = (state == DRIVE);

    settle_timer #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            vec      <= '0;
            exp_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            f_table  <= '0;
            mismatch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q    <= expected;
                        f_table  <= '0;
                        pass     <= 1'b0;
                        mismatch <= '0;
                        idx      <= '0;
                        vec      <= '0;
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (tmr_expire)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    f_table <= tbl_nxt;
                    if (idx == LAST_IDX) begin
                        pass     <= (tbl_nxt == exp_q);
                        mismatch <= tbl_nxt ^ exp_q;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        vec   <= idx + 1'b1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a = vec[2];
    assign b = vec[1];
    assign c = vec[0];

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SETTLE=1 instance
    logic       rst1, start1, a1, b1, c1, f1, busy1, done1, pass1;
    logic [7:0] exp1, tbl1, mis1, tt1;
    assign f1 = tt1[{a1, b1, c1}];

    truth_table_scanner #(.SETTLE(1)) u1 (
        .clk(clk), .reset(rst1), .start(start1), .expected(exp1),
        .a(a1), .b(b1), .c(c1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .f_table(tbl1), .mismatch(mis1)
    );

    // SETTLE=3 instance
    logic       rst3, start3, a3, b3, c3, f3, busy3, done3, pass3;
    logic [7:0] exp3, tbl3, mis3, tt3;
    assign f3 = tt3[{a3, b3, c3}];

    truth_table_scanner #(.SETTLE(3)) u3 (
        .clk(clk), .reset(rst3), .start(start3), .expected(exp3),
        .a(a3), .b(b3), .c(c3), .f(f3),
        .busy(busy3), .done(done3), .pass(pass3),
        .f_table(tbl3), .mismatch(mis3)
    );

    // Pulse start on u1 and return at the negedge where done is seen.
    // dcyc = cycles after the start edge (first cycle after it is 1), -1 on timeout.
    task automatic scan1(input logic [7:0] e, output int dcyc);
        int n;
        @(negedge clk);
        exp1   = e;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        dcyc = (done1 === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        start1 = 1'b0; start3 = 1'b0;
        exp1 = 8'hA5; exp3 = 8'h5A;
        tt1 = 8'hFF; tt3 = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, tbl1, mis1} !== 22'd0) begin
            errors++;
            $display("FAIL reset_u1: got abc=%b%b%b busy=%b done=%b pass=%b tbl=%h mis=%h, want all 0",
                     a1, b1, c1, busy1, done1, pass1, tbl1, mis1);
        end
        checks++;
        if ({a3, b3, c3, busy3, done3, pass3, tbl3, mis3} !== 22'd0) begin
            errors++;
            $display("FAIL reset_u3: got abc=%b%b%b busy=%b done=%b pass=%b tbl=%h mis=%h, want all 0",
                     a3, b3, c3, busy3, done3, pass3, tbl3, mis3);
        end
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    // f = ~((~a&b)|(~b&c)) evaluated per vector, expected 0xD1 then 0xD0
    task automatic test_basic();
        int d;
        logic [7:0] ref_tt;
        ref_tt = '0;
        for (int i = 0; i < 8; i++) begin
            logic va, vb, vc;
            va = i[2]; vb = i[1]; vc = i[0];
            ref_tt[i] = ~((~va & vb) | (~vb & vc));
        end
        tt1 = ref_tt;
        scan1(8'hD1, d);
        checks++;
        if (d !== 17) begin errors++; $display("FAIL basic_done_cycle: got %0d want 17", d); end
        checks++;
        if (tbl1 !== 8'hD1) begin errors++; $display("FAIL basic_table: got %h want d1", tbl1); end
        checks++;
        if (pass1 !== 1'b1 || mis1 !== 8'h00) begin
            errors++; $display("FAIL basic_pass: got pass=%b mis=%h want pass=1 mis=00", pass1, mis1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || {a1, b1, c1} !== 3'b111) begin
            errors++;
            $display("FAIL basic_after_done: got done=%b busy=%b abc=%b%b%b want 0 0 111", done1, busy1, a1, b1, c1);
        end
        // results hold while idle even if expected moves
        exp1 = 8'h3C;
        repeat (3) @(negedge clk);
        checks++;
        if (pass1 !== 1'b1 || tbl1 !== 8'hD1 || {a1, b1, c1} !== 3'b111) begin
            errors++; $display("FAIL basic_hold: got pass=%b tbl=%h abc=%b%b%b want 1 d1 111", pass1, tbl1, a1, b1, c1);
        end

        scan1(8'hD0, d);
        checks++;
        if (pass1 !== 1'b0 || mis1 !== 8'h01 || tbl1 !== 8'hD1) begin
            errors++; $display("FAIL mismatch_d0: got pass=%b mis=%h tbl=%h want 0 01 d1", pass1, mis1, tbl1);
        end
    endtask

    task automatic test_random();
        int d;
        logic [7:0] e;
        for (int k = 0; k < 8; k++) begin
            tt1 = 8'($urandom);
            case (k % 3)
                0: e = tt1;
                1: e = tt1 ^ (8'h01 << $urandom_range(7, 0));
                default: e = 8'($urandom);
            endcase
            scan1(e, d);
            checks++;
            if (d !== 17 || tbl1 !== tt1 || mis1 !== (tt1 ^ e) || pass1 !== (tt1 == e)) begin
                errors++;
                $display("FAIL random_%0d: got done@%0d tbl=%h mis=%h pass=%b want done@17 tbl=%h mis=%h pass=%b",
                         k, d, tbl1, mis1, pass1, tt1, tt1 ^ e, (tt1 == e));
            end
        end
    endtask

    // SETTLE=3, f = a
    task automatic test_settle3();
        int n, bad;
        logic [2:0] v;
        tt3 = 8'hF0;
        @(negedge clk);
        exp3   = 8'hF0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 1; bad = 0;
        while (done3 !== 1'b1 && n < 200) begin
            v = 3'((n - 1) / 4);
            if (n <= 32 && {a3, b3, c3} !== v) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL settle3_hold: got %0d cycles with wrong vector want 0", bad); end
        checks++;
        if (done3 !== 1'b1 || n != 33) begin errors++; $display("FAIL settle3_done_cycle: got %0d want 33", n); end
        checks++;
        if (tbl3 !== 8'hF0 || pass3 !== 1'b1 || mis3 !== 8'h00) begin
            errors++; $display("FAIL settle3_table: got tbl=%h pass=%b mis=%h want f0 1 00", tbl3, pass3, mis3);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        logic [7:0] e;
        tt1 = 8'($urandom) | 8'h01;
        e   = tt1;
        @(negedge clk);
        exp1   = e;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 200) begin
            if (n == 6) begin start1 = 1'b1; exp1 = 8'h00; end
            if (n == 7) start1 = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (done1 !== 1'b1 || n != 17) begin errors++; $display("FAIL ignore_start_done: got %0d want 17", n); end
        checks++;
        if (pass1 !== 1'b1 || mis1 !== 8'h00 || tbl1 !== e) begin
            errors++; $display("FAIL ignore_start_result: got pass=%b mis=%h tbl=%h want 1 00 %h", pass1, mis1, tbl1, e);
        end
    endtask

    task automatic test_reset_mid();
        int n, d;
        tt1 = 8'($urandom) | 8'h0F;
        @(negedge clk);
        exp1   = tt1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!(a1 === 1'b1 && b1 === 1'b0 && c1 === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL reset_mid_reach_i4: got timeout want vector 100"); end
        // reset wins over a simultaneous start
        rst1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, tbl1, mis1} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got abc=%b%b%b busy=%b done=%b pass=%b tbl=%h mis=%h want all 0",
                     a1, b1, c1, busy1, done1, pass1, tbl1, mis1);
        end
        rst1 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got busy=%b want 0", busy1); end
        scan1(tt1, d);
        checks++;
        if (d !== 17 || tbl1 !== tt1 || pass1 !== 1'b1) begin
            errors++; $display("FAIL reset_mid_rescan: got done@%0d tbl=%h pass=%b want 17 %h 1", d, tbl1, pass1, tt1);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        tt1 = 8'($urandom);
        @(negedge clk);
        exp1   = tt1;
        start1 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done1 === 1'b1) dq.push_back(n);
        end
        start1 = 1'b0;
        checks++;
        if (dq.size() != 2 || dq[0] != 17 || dq[1] != 35) begin
            errors++;
            $display("FAIL back_to_back_done: got %0d pulses first=%0d second=%0d want 2 pulses at 17 35",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || pass1 !== 1'b1 || tbl1 !== tt1) begin
            errors++; $display("FAIL back_to_back_final: got busy=%b pass=%b tbl=%h want 0 1 %h", busy1, pass1, tbl1, tt1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_settle3();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
